pcs_link_supervisor: RTL and testbench
======================================

Name: pcs_link_supervisor

Overview:
- Per-channel bring-up and health supervisor for N_CH SFP 1000BASE-X PCS/PMA links feeding SiTCP.
- Sequence per channel: power-on holdoff → PCS reset pulse → wait resetdone → MII initializer kick → wait link → monitor.
- Retries on timeout or link loss, up to MAX_RETRY attempts; then the channel parks in FAIL.
- Sits between the PCS/PMA example-design instances and the mii_initializer/SiTCP layer, clocked in the rxuserclk2 (125 MHz) domain.

Parameters:
N_CH, 1, number of independent SFP channels (1..8)
POR_CYC, 16, cycles after reset/enable before first PCS reset
PULSE_W, 4, PCS reset pulse width in cycles (>=1)
DONE_TO, 1000000, max cycles waiting for resetdone rising edge
MII_TO, 65536, max cycles waiting for mii_complete
LINK_TO, 2000000, max cycles waiting for link_up after MII complete
LOSS_CYC, 1024, consecutive link_up-low cycles in UP that count as link loss
MAX_RETRY, 8, reset attempts before FAIL (1..255)

Ports:
CLK  in  1  system clock (rxuserclk2 domain)
RSTn  in  1  synchronous active-low reset
enable  in  N_CH  per-channel enable, level
force_retry  in  N_CH  1-cycle pulse: restart channel, clear retry_cnt
resetdone  in  N_CH  PCS/PMA resetdone, asynchronous
link_up  in  N_CH  status_vector[0] per channel, asynchronous
mii_complete  in  N_CH  mii_initializer COMPLETE, synchronous
pcs_reset  out  N_CH  PCS/PMA reset, active high
mii_rst  out  N_CH  1-cycle reset pulse to mii_initializer RST
link_ok  out  N_CH  channel in UP
fail  out  N_CH  channel in FAIL
state  out  3*N_CH  per-channel state code, channel i at [3i+2:3i]
retry_cnt  out  8*N_CH  per-channel attempt count, channel i at [8i+7:8i]
all_up  out  1  AND of link_ok over enabled channels; 0 if no channel is enabled

Behaviour:
- Sync: resetdone and link_up pass through 2-flop synchronisers. Edge detection on the synchronised resetdone uses a 3rd flop, so the rising edge is visible 3 cycles after the async edge.
- Reset (RSTn=0 at posedge): all channels go to IDLE.
  - pcs_reset=all 1, mii_rst=0, link_ok=0, fail=0, retry_cnt=0, state=0, all_up=0.
  - Synchroniser and counter flops clear.
- State codes: IDLE=0, POR=1, RST=2, WDONE=3, MII=4, WLINK=5, UP=6, FAIL=7.
- IDLE: pcs_reset=1. Moves to POR when enable[i]=1.
- POR: pcs_reset=1; counts POR_CYC cycles, then → RST.
- RST:
  - pcs_reset=1 for exactly PULSE_W cycles, then → WDONE.
  - retry_cnt increments (saturating at 255) on RST entry.
- WDONE: pcs_reset=0.
  - Synchronised resetdone rising edge → MII, with mii_rst=1 for that single entry cycle.
  - Timeout after DONE_TO cycles → retry.
- MII: mii_complete=1 → WLINK; timeout after MII_TO cycles → retry.
- WLINK: synchronised link_up=1 → UP; timeout after LINK_TO cycles → retry.
- UP:
  - link_ok=1; retry_cnt is cleared to 0 on UP entry.
  - A run of LINK_ONLY-low cycles reaching LOSS_CYC (link_up low for LOSS_CYC consecutive cycles) → retry. Any high cycle resets the loss counter.
- retry:
  - If retry_cnt < MAX_RETRY → RST.
  - Else → FAIL: pcs_reset=1, fail=1, held until force_retry or enable drop.
- enable[i]=0 in any state → IDLE next cycle; pcs_reset=1; retry_cnt kept.
- force_retry[i]=1 with enable[i]=1 in any state → POR next cycle, retry_cnt=0. If force_retry and enable-drop coincide, enable-drop wins.
- Counter/state precedence in the same cycle: RSTn > enable drop > force_retry > normal transition.
- Timeout counters are $clog2(param+1) wide, restart at 0 on every state entry, and fire when count == param−1 (exactly param cycles in state).
- Channels are fully independent; no shared counters.
- Outputs are registered; every output reflects the state one cycle after the transition decision.

Test Plan:
- N_CH=1, POR_CYC=16, PULSE_W=4; release RSTn, enable=1 → pcs_reset falls exactly 16+4 cycles after POR entry; retry_cnt=1.
- resetdone rises async → mii_rst 1-cycle pulse 3–4 cycles later; mii_complete=1 → WLINK; link_up=1 → link_ok=1, retry_cnt=0, all_up=1.
- DONE_TO=100, MAX_RETRY=3, resetdone held 0 → three RST pulses spaced 100+PULSE_W cycles apart, then fail=1, state=7, pcs_reset=1; force_retry → state=1, retry_cnt=0.
- LOSS_CYC=1024 in UP: link_up low 1023 cycles then high → stays UP; low 1024 cycles → state=2, link_ok=0, retry_cnt=1.
- N_CH=4, channel 2 disabled, others UP → all_up=1; drop enable[0] → state0=0, pcs_reset[0]=1, all_up=0; other channels unaffected.
- RSTn=0 mid-WLINK on all channels → next cycle all state=0, pcs_reset=all 1, retry_cnt=0; force_retry and enable-drop same cycle → IDLE.

Source files
------------

// File: rtl/pcs_link_supervisor_if.sv
// Bundle of per-channel control/status lines between the PCS/PMA side,
// the mii_initializer/SiTCP side and the link supervisor.
`timescale 1ns/1ps
interface pcs_link_supervisor_if #(
    parameter int N_CH = 1
);
    logic [N_CH-1:0]   enable;
    logic [N_CH-1:0]   force_retry;
    logic [N_CH-1:0]   resetdone;
    logic [N_CH-1:0]   link_up;
    logic [N_CH-1:0]   mii_complete;
    logic [N_CH-1:0]   pcs_reset;
    logic [N_CH-1:0]   mii_rst;
    logic [N_CH-1:0]   link_ok;
    logic [N_CH-1:0]   fail;
    logic [3*N_CH-1:0] state;
    logic [8*N_CH-1:0] retry_cnt;
    logic              all_up;

    // Surrounding system: drives enables and raw PCS/MII status, observes supervisor outputs
    modport master (
        output enable, force_retry, resetdone, link_up, mii_complete,
        input  pcs_reset, mii_rst, link_ok, fail, state, retry_cnt, all_up
    );

    // Supervisor itself
    modport slave (
        input  enable, force_retry, resetdone, link_up, mii_complete,
        output pcs_reset, mii_rst, link_ok, fail, state, retry_cnt, all_up
    );
endinterface

// File: rtl/pcs_link_supervisor.sv
// Per-channel bring-up and health supervisor for SFP 1000BASE-X PCS/PMA links.
// Each channel walks IDLE -> POR -> RST -> WDONE -> MII -> WLINK -> UP and
// retries from RST on timeout or link loss until its attempt budget runs out.
`timescale 1ns/1ps
module pcs_link_supervisor #(
    parameter int N_CH      = 1,
    parameter int POR_CYC   = 16,
    parameter int PULSE_W   = 4,
    parameter int DONE_TO   = 1000000,
    parameter int MII_TO    = 65536,
    parameter int LINK_TO   = 2000000,
    parameter int LOSS_CYC  = 1024,
    parameter int MAX_RETRY = 8
) (
    input logic                  CLK,
    input logic                  RSTn,
    pcs_link_supervisor_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POR   = 3'd1,
        RST   = 3'd2,
        WDONE = 3'd3,
        MII   = 3'd4,
        WLINK = 3'd5,
        UP    = 3'd6,
        FAIL  = 3'd7
    } chanState_e;

    // One shared-per-channel timer covers every timed state, so it is sized for the longest one
    localparam int T1   = (POR_CYC > PULSE_W) ? POR_CYC : PULSE_W;
    localparam int T2   = (T1 > DONE_TO) ? T1 : DONE_TO;
    localparam int T3   = (T2 > MII_TO) ? T2 : MII_TO;
    localparam int TMAX = (T3 > LINK_TO) ? T3 : LINK_TO;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int LW   = $clog2(LOSS_CYC + 1);

    chanState_e      state_q [N_CH];
    chanState_e      state_d [N_CH];
    logic [TW-1:0]   timer_q [N_CH];
    logic [TW-1:0]   timer_d [N_CH];
    logic [LW-1:0]   loss_q  [N_CH];
    logic [LW-1:0]   loss_d  [N_CH];
    logic [7:0]      retry_q [N_CH];
    logic [7:0]      retry_d [N_CH];

    logic [N_CH-1:0] rdSync1_q, rdSync2_q, rdSync3_q;
    logic [N_CH-1:0] luSync1_q, luSync2_q;
    logic [N_CH-1:0] rdRise, forceHit, goRetry, stateEntry;

    logic [N_CH-1:0] pcsReset_q, pcsReset_d;
    logic [N_CH-1:0] miiRst_q, miiRst_d;
    logic [N_CH-1:0] linkOk_q, linkOk_d;
    logic [N_CH-1:0] fail_q, fail_d;
    logic            allUp_q, allUp_d;

    logic [3*N_CH-1:0] stateVec;
    logic [8*N_CH-1:0] retryVec;

    assign rdRise   = rdSync2_q & ~rdSync3_q;
    assign forceHit = bus.force_retry & bus.enable;

    // Bring the asynchronous PCS status lines into the clock domain; third resetdone flop gives edge detect
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            rdSync1_q <= '0;
            rdSync2_q <= '0;
            rdSync3_q <= '0;
            luSync1_q <= '0;
            luSync2_q <= '0;
        end else begin
            rdSync1_q <= bus.resetdone;
            rdSync2_q <= rdSync1_q;
            rdSync3_q <= rdSync2_q;
            luSync1_q <= bus.link_up;
            luSync2_q <= luSync1_q;
        end
    end

    // Per-channel next state, counters and registered-output next values
    always_comb begin
        goRetry    = '0;
        stateEntry = '0;
        pcsReset_d = '0;
        miiRst_d   = '0;
        linkOk_d   = '0;
        fail_d     = '0;
        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            timer_d[i] = timer_q[i];
            loss_d[i]  = '0;
            retry_d[i] = retry_q[i];

            case (state_q[i])
                IDLE: begin
                    if (bus.enable[i]) state_d[i] = POR;
                end
                POR: begin
                    timer_d[i] = timer_q[i] + TW'(1);
                    if (timer_q[i] == TW'(POR_CYC - 1)) state_d[i] = RST;
                end
                RST: begin
                    timer_d[i] = timer_q[i] + TW'(1);
                    if (timer_q[i] == TW'(PULSE_W - 1)) state_d[i] = WDONE;
                end
                WDONE: begin
                    timer_d[i] = timer_q[i] + TW'(1);
                    if (rdRise[i])                           state_d[i] = MII;
                    else if (timer_q[i] == TW'(DONE_TO - 1)) goRetry[i] = 1'b1;
                end
                MII: begin
                    timer_d[i] = timer_q[i] + TW'(1);
                    if (bus.mii_complete[i])                state_d[i] = WLINK;
                    else if (timer_q[i] == TW'(MII_TO - 1)) goRetry[i] = 1'b1;
                end
                WLINK: begin
                    timer_d[i] = timer_q[i] + TW'(1);
                    if (luSync2_q[i])                        state_d[i] = UP;
                    else if (timer_q[i] == TW'(LINK_TO - 1)) goRetry[i] = 1'b1;
                end
                UP: begin
                    if (luSync2_q[i])                          loss_d[i] = '0;
                    else if (loss_q[i] == LW'(LOSS_CYC - 1))   goRetry[i] = 1'b1;
                    else                                       loss_d[i] = loss_q[i] + LW'(1);
                end
                FAIL: begin
                    state_d[i] = FAIL;
                end
                default: state_d[i] = IDLE;
            endcase

            if (goRetry[i]) begin
                state_d[i] = (retry_q[i] < 8'(MAX_RETRY)) ? RST : FAIL;
            end

            // Restart request outranks normal progress; dropping enable outranks both
            if (forceHit[i]) begin
                state_d[i] = POR;
                retry_d[i] = '0;
            end
            if (!bus.enable[i]) begin
                state_d[i] = IDLE;
            end

            // A forced restart re-enters POR even from POR, so it counts as an entry too
            stateEntry[i] = (state_d[i] != state_q[i]) || forceHit[i];
            if (stateEntry[i]) begin
                timer_d[i] = '0;
                loss_d[i]  = '0;
                if (state_d[i] == RST) begin
                    retry_d[i] = (retry_q[i] == 8'hFF) ? 8'hFF : retry_q[i] + 8'd1;
                end else if (state_d[i] == UP) begin
                    retry_d[i] = '0;
                end
            end

            pcsReset_d[i] = (state_d[i] == IDLE) || (state_d[i] == POR) ||
                            (state_d[i] == RST)  || (state_d[i] == FAIL);
            miiRst_d[i]   = stateEntry[i] && (state_d[i] == MII);
            linkOk_d[i]   = (state_d[i] == UP);
            fail_d[i]     = (state_d[i] == FAIL);
        end
        allUp_d = (|bus.enable) & (&(linkOk_d | ~bus.enable));
    end

    // Channel state, counters and registered outputs
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= IDLE;
                timer_q[i] <= '0;
                loss_q[i]  <= '0;
                retry_q[i] <= '0;
            end
            pcsReset_q <= '1;
            miiRst_q   <= '0;
            linkOk_q   <= '0;
            fail_q     <= '0;
            allUp_q    <= 1'b0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                timer_q[i] <= timer_d[i];
                loss_q[i]  <= loss_d[i];
                retry_q[i] <= retry_d[i];
            end
            pcsReset_q <= pcsReset_d;
            miiRst_q   <= miiRst_d;
            linkOk_q   <= linkOk_d;
            fail_q     <= fail_d;
            allUp_q    <= allUp_d;
        end
    end

    // Flatten per-channel state and attempt count into the packed status buses
    always_comb begin
        stateVec = '0;
        retryVec = '0;
        for (int i = 0; i < N_CH; i++) begin
            stateVec[3*i +: 3] = state_q[i];
            retryVec[8*i +: 8] = retry_q[i];
        end
    end

    assign bus.pcs_reset = pcsReset_q;
    assign bus.mii_rst   = miiRst_q;
    assign bus.link_ok   = linkOk_q;
    assign bus.fail      = fail_q;
    assign bus.state     = stateVec;
    assign bus.retry_cnt = retryVec;
    assign bus.all_up    = allUp_q;

endmodule

// File: tb/tb_pcs_link_supervisor.sv
// Directed bench for pcs_link_supervisor: four channels, short timeouts,
// hand-computed cycle positions for each expected transition.
`timescale 1ns/1ps
module tb_pcs_link_supervisor;
    localparam int N_CH      = 4;
    localparam int POR_CYC   = 16;
    localparam int PULSE_W   = 4;
    localparam int DONE_TO   = 100;
    localparam int MII_TO    = 64;
    localparam int LINK_TO   = 300;
    localparam int LOSS_CYC  = 1024;
    localparam int MAX_RETRY = 3;

    logic CLK  = 1'b0;
    logic RSTn = 1'b0;
    int   total = 0;
    int   bad   = 0;

    // Free-running 100 MHz clock
    always #5 CLK = ~CLK;

    pcs_link_supervisor_if #(.N_CH(N_CH)) bus ();

    pcs_link_supervisor #(
        .N_CH(N_CH), .POR_CYC(POR_CYC), .PULSE_W(PULSE_W), .DONE_TO(DONE_TO),
        .MII_TO(MII_TO), .LINK_TO(LINK_TO), .LOSS_CYC(LOSS_CYC), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .CLK (CLK),
        .RSTn(RSTn),
        .bus (bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] en, input logic [3:0] fr, input logic [3:0] rd,
                                 input logic [3:0] lu, input logic [3:0] mc);
        bus.enable       = en;
        bus.force_retry  = fr;
        bus.resetdone    = rd;
        bus.link_up      = lu;
        bus.mii_complete = mc;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic waitState(input int ch, input logic [2:0] code, input int maxCyc, input string tag);
        int n = 0;
        while (bus.state[3*ch +: 3] !== code && n < maxCyc) begin
            @(negedge CLK);
            n++;
        end
        checkOutput(tag, 32'(bus.state[3*ch +: 3]), 32'(code));
    endtask

    // Hard stop in case the sequence below ever stalls
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence
    initial begin
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        RSTn = 1'b0;
        tick(3);
        checkOutput("rst_pcs_reset", 32'(bus.pcs_reset), 32'hF);
        checkOutput("rst_state",     32'(bus.state),     32'h0);
        checkOutput("rst_retry",     32'(bus.retry_cnt), 32'h0);
        checkOutput("rst_link_ok",   32'(bus.link_ok),   32'h0);
        checkOutput("rst_fail",      32'(bus.fail),      32'h0);
        checkOutput("rst_mii_rst",   32'(bus.mii_rst),   32'h0);
        checkOutput("rst_all_up",    32'(bus.all_up),    32'h0);

        RSTn = 1'b1;
        tick(2);
        checkOutput("idle_no_enable", 32'(bus.state), 32'h0);

        // Bring-up on channel 0: POR entry, then exactly 16+4 cycles of pcs_reset
        applyStimulus(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        tick(1);
        checkOutput("por_entry", 32'(bus.state[2:0]), 32'd1);
        tick(19);
        checkOutput("rst_pulse_state", 32'(bus.state[2:0]), 32'd2);
        checkOutput("rst_pulse_retry", 32'(bus.retry_cnt[7:0]), 32'd1);
        checkOutput("rst_pulse_pcs",   32'(bus.pcs_reset[0]), 32'd1);
        tick(1);
        checkOutput("wdone_state", 32'(bus.state[2:0]), 32'd3);
        checkOutput("wdone_pcs",   32'(bus.pcs_reset[0]), 32'd0);

        // resetdone edge reaches the FSM three cycles later; mii_rst lasts one cycle
        applyStimulus(4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        tick(2);
        checkOutput("mii_rst_early", 32'(bus.mii_rst[0]), 32'd0);
        tick(1);
        checkOutput("mii_rst_pulse", 32'(bus.mii_rst[0]), 32'd1);
        checkOutput("mii_state",     32'(bus.state[2:0]), 32'd4);
        tick(1);
        checkOutput("mii_rst_end",   32'(bus.mii_rst[0]), 32'd0);

        applyStimulus(4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001);
        tick(1);
        checkOutput("wlink_state", 32'(bus.state[2:0]), 32'd5);

        applyStimulus(4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
        waitState(0, 3'd6, 10, "up_state");
        checkOutput("up_link_ok", 32'(bus.link_ok), 32'h1);
        checkOutput("up_retry",   32'(bus.retry_cnt[7:0]), 32'd0);
        checkOutput("up_all_up",  32'(bus.all_up), 32'd1);

        // Link loss: 1023 low cycles is tolerated, 1024 triggers a retry
        tick(3);
        applyStimulus(4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        tick(1023);
        applyStimulus(4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
        tick(5);
        checkOutput("loss_1023_stays_up", 32'(bus.state[2:0]), 32'd6);

        applyStimulus(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        tick(1025);
        checkOutput("loss_1024_edge_up", 32'(bus.state[2:0]), 32'd6);
        tick(1);
        checkOutput("loss_retry_state", 32'(bus.state[2:0]), 32'd2);
        checkOutput("loss_link_ok",     32'(bus.link_ok[0]), 32'd0);
        checkOutput("loss_retry_cnt",   32'(bus.retry_cnt[7:0]), 32'd1);

        // No resetdone edge: WDONE times out every DONE_TO cycles until the budget is spent
        tick(103);
        checkOutput("to1_wdone", 32'(bus.state[2:0]), 32'd3);
        tick(1);
        checkOutput("to1_rst",   32'(bus.state[2:0]), 32'd2);
        checkOutput("to1_retry", 32'(bus.retry_cnt[7:0]), 32'd2);
        tick(103);
        checkOutput("to2_wdone", 32'(bus.state[2:0]), 32'd3);
        tick(1);
        checkOutput("to2_rst",   32'(bus.state[2:0]), 32'd2);
        checkOutput("to2_retry", 32'(bus.retry_cnt[7:0]), 32'd3);
        tick(104);
        checkOutput("fail_state", 32'(bus.state[2:0]), 32'd7);
        checkOutput("fail_flag",  32'(bus.fail[0]), 32'd1);
        checkOutput("fail_pcs",   32'(bus.pcs_reset[0]), 32'd1);

        applyStimulus(4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        tick(1);
        checkOutput("force_state", 32'(bus.state[2:0]), 32'd1);
        checkOutput("force_retry", 32'(bus.retry_cnt[7:0]), 32'd0);
        checkOutput("force_fail",  32'(bus.fail[0]), 32'd0);

        // Channels 0,1,3 up with channel 2 disabled
        applyStimulus(4'b1011, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        tick(25);
        applyStimulus(4'b1011, 4'b0000, 4'b1011, 4'b1011, 4'b1011);
        waitState(3, 3'd6, 20, "multi_ch3_up");
        tick(2);
        checkOutput("multi_state",   32'(bus.state), 32'hC36);
        checkOutput("multi_link_ok", 32'(bus.link_ok), 32'hB);
        checkOutput("multi_all_up",  32'(bus.all_up), 32'd1);
        checkOutput("multi_retry",   32'(bus.retry_cnt), 32'h0);

        applyStimulus(4'b1010, 4'b0000, 4'b1011, 4'b1011, 4'b1011);
        tick(1);
        checkOutput("drop0_state",   32'(bus.state), 32'hC30);
        checkOutput("drop0_pcs",     32'(bus.pcs_reset), 32'h5);
        checkOutput("drop0_link_ok", 32'(bus.link_ok), 32'hA);

        // Enable drop beats a coincident force_retry
        applyStimulus(4'b1000, 4'b0010, 4'b1011, 4'b1011, 4'b1011);
        tick(1);
        checkOutput("drop_vs_force_state", 32'(bus.state), 32'hC00);
        checkOutput("drop_vs_force_allup", 32'(bus.all_up), 32'd1);

        // Restart all four together and park them in WLINK
        applyStimulus(4'b1111, 4'b1000, 4'b0000, 4'b0000, 4'b0000);
        tick(1);
        checkOutput("restart_state",  32'(bus.state), 32'h249);
        checkOutput("restart_all_up", 32'(bus.all_up), 32'd0);
        applyStimulus(4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        tick(25);
        applyStimulus(4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b1111);
        tick(8);
        checkOutput("wlink_all_state", 32'(bus.state), 32'hB6D);
        checkOutput("wlink_all_retry", 32'(bus.retry_cnt), 32'h01010101);

        RSTn = 1'b0;
        tick(1);
        checkOutput("midrst_state", 32'(bus.state), 32'h0);
        checkOutput("midrst_pcs",   32'(bus.pcs_reset), 32'hF);
        checkOutput("midrst_retry", 32'(bus.retry_cnt), 32'h0);
        checkOutput("midrst_allup", 32'(bus.all_up), 32'd0);
        RSTn = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
